elastic_pipe_stage: RTL and testbench

- Parametrised, full-throughput pipeline slice for the RX→Parser, Parser→Logic and Logic→TX boundaries.
- Replaces the single-entry, half-rate register with a DEPTH-entry elastic buffer using a valid/ready handshake on both sides.
- Each accepted word is stamped with cycle_cnt at ingress; the stamp travels with the data, and egress residency latency is reported.
- Adds sync flush, occupancy and high-water-mark observability.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/elastic_pipe_stage.sv | 106 ++++++++++
 tb/tb_elastic_pipe_stage.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline stages.
package pipe_pkg;

  localparam int unsigned DefaultTsW = 32;

  typedef logic [DefaultTsW-1:0] ts_t;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// DEPTH-entry valid/ready elastic buffer; each word carries its ingress cycle stamp
// so egress can report how long it sat in the stage.
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned TS_W   = DefaultTsW,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [TS_W-1:0]   cycle_cnt,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [TS_W-1:0]   out_ts,
  input  logic              out_ready,
  output logic [TS_W-1:0]   out_lat,
  output logic [CNT_W-1:0]  level,
  output logic [CNT_W-1:0]  hwm
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam ptr_t LastPtr   = PTR_W'(DEPTH - 1);
  localparam cnt_t DepthCnt  = CNT_W'(DEPTH);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [TS_W-1:0]   ts_mem   [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  cnt_t hwm_q, hwm_d;

  logic push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = rst_n & (count_q < DepthCnt);
  assign out_valid = (count_q != '0);
  assign out_data  = data_mem[rd_ptr_q];
  assign out_ts    = ts_mem[rd_ptr_q];
  assign out_lat   = cycle_cnt - out_ts;
  assign level     = count_q;
  assign hwm       = hwm_q;

  always_comb begin
    push     = in_valid & in_ready & ~flush;
    pop      = out_valid & out_ready & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hwm_d    = hwm_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      hwm_d    = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hwm_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hwm_q    <= hwm_d;
    end
  end

  // Storage is deliberately left unreset; out_valid gates its meaning.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= in_data;
      ts_mem[wr_ptr_q]   <= cycle_cnt;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Bench for elastic_pipe_stage: four instances with DEPTH 1..4 checked against a queue model.
module tb_elastic_pipe_stage;

  localparam int NInst = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] cycle_cnt;
  logic        chk_en;

  logic        iv   [NInst];
  logic [7:0]  id   [NInst];
  logic        ir   [NInst];
  logic        ov   [NInst];
  logic [7:0]  od   [NInst];
  logic [31:0] ots  [NInst];
  logic        ordy [NInst];
  logic [31:0] olat [NInst];
  logic [2:0]  lvl  [NInst];
  logic [2:0]  hw   [NInst];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    localparam int unsigned CW = pipe_pkg::cnt_width(g + 1);
    logic [CW-1:0] lvl_w, hwm_w;

    elastic_pipe_stage #(
      .DATA_W(8),
      .DEPTH (g + 1),
      .TS_W  (32)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .cycle_cnt(cycle_cnt),
      .in_valid (iv[g]),
      .in_data  (id[g]),
      .in_ready (ir[g]),
      .out_valid(ov[g]),
      .out_data (od[g]),
      .out_ts   (ots[g]),
      .out_ready(ordy[g]),
      .out_lat  (olat[g]),
      .level    (lvl_w),
      .hwm      (hwm_w)
    );

    assign lvl[g] = 3'(lvl_w);
    assign hw[g]  = 3'(hwm_w);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs only change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cycle_cnt = cycle_cnt + 32'd1;
  endtask

  // Model: an ordered queue of {data, stamp} per instance plus a running maximum.
  logic [39:0] mq   [NInst][$];
  int unsigned mhwm [NInst];

  always @(posedge clk) begin
    for (int k = 0; k < NInst; k++) begin
      if (!rst_n || flush) begin
        mq[k].delete();
        mhwm[k] = 0;
      end else begin
        bit do_push, do_pop;
        do_push = iv[k] && (mq[k].size() < k + 1);
        do_pop  = (mq[k].size() != 0) && ordy[k];
        if (do_pop) void'(mq[k].pop_front());
        if (do_push) mq[k].push_back({id[k], cycle_cnt});
        if (mq[k].size() > mhwm[k]) mhwm[k] = mq[k].size();
      end
    end
  end

  logic       p_hold [NInst];
  logic [7:0] p_od   [NInst];

  initial for (int k = 0; k < NInst; k++) p_hold[k] = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NInst; k++) begin
        int sz;
        logic [39:0] h;
        sz = mq[k].size();
        check($sformatf("in_ready[%0d]", k), 64'(ir[k]), 64'(rst_n && (sz < k + 1)));
        check($sformatf("out_valid[%0d]", k), 64'(ov[k]), 64'(sz != 0));
        check($sformatf("level[%0d]", k), 64'(lvl[k]), 64'(sz));
        check($sformatf("hwm[%0d]", k), 64'(hw[k]), 64'(mhwm[k]));
        check($sformatf("level_le_depth[%0d]", k), 64'(int'(lvl[k]) <= k + 1), 64'd1);
        if (sz != 0) begin
          h = mq[k][0];
          check($sformatf("out_data[%0d]", k), 64'(od[k]), 64'(h[39:32]));
          check($sformatf("out_ts[%0d]", k), 64'(ots[k]), 64'(h[31:0]));
          check($sformatf("out_lat[%0d]", k), 64'(olat[k]), 64'(32'(cycle_cnt - h[31:0])));
        end
        if (p_hold[k] && rst_n) check($sformatf("data_stable[%0d]", k), 64'(od[k]), 64'(p_od[k]));
        p_hold[k] = ov[k] && !ordy[k] && rst_n && !flush;
        p_od[k]   = od[k];
      end
    end
  end

  initial begin
    int j;
    int acc_cnt;
    logic acc;

    rst_n = 1'b0;
    flush = 1'b0;
    cycle_cnt = '0;
    chk_en = 1'b0;
    for (int k = 0; k < NInst; k++) begin
      iv[k] = 1'b0;
      id[k] = 8'h00;
      ordy[k] = 1'b0;
    end
    step();
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state, then fill DEPTH=2 and reset mid-stream.
    @(negedge clk);
    check("reset out_valid", 64'(ov[1]), 64'd0);
    check("reset in_ready", 64'(ir[1]), 64'd1);
    check("reset level", 64'(lvl[1]), 64'd0);
    check("reset hwm", 64'(hw[1]), 64'd0);
    step();
    iv[1] = 1'b1;
    id[1] = 8'h55;
    step();
    id[1] = 8'h66;
    step();
    iv[1] = 1'b0;
    @(negedge clk);
    check("full level", 64'(lvl[1]), 64'd2);
    check("full in_ready", 64'(ir[1]), 64'd0);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("in_ready low in reset", 64'(ir[1]), 64'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset out_valid", 64'(ov[1]), 64'd0);
    check("post reset in_ready", 64'(ir[1]), 64'd1);
    check("post reset level", 64'(lvl[1]), 64'd0);
    check("post reset hwm", 64'(hw[1]), 64'd0);

    // Streaming at full rate through DEPTH=2.
    step();
    cycle_cnt = 32'd100;
    iv[1] = 1'b1;
    ordy[1] = 1'b1;
    id[1] = 8'h01;
    for (int n = 1; n <= 16; n++) begin
      step();
      id[1] = 8'(n + 1);
      @(negedge clk);
      check("stream data", 64'(od[1]), 64'(n));
      check("stream ts", 64'(ots[1]), 64'(99 + n));
      check("stream lat", 64'(olat[1]), 64'd1);
      check("stream level", 64'(lvl[1]), 64'd1);
      check("stream hwm", 64'(hw[1]), 64'd1);
    end
    step();
    iv[1] = 1'b0;
    step();
    step();
    ordy[1] = 1'b0;

    // Backpressure on DEPTH=4.
    j = 0;
    iv[3] = 1'b1;
    id[3] = 8'hA0;
    for (int c = 0; c < 20 && j < 6; c++) begin
      if (c == 6) ordy[3] = 1'b1;
      @(negedge clk);
      acc = ir[3];
      if (c == 5) begin
        check("bp level", 64'(lvl[3]), 64'd4);
        check("bp hwm", 64'(hw[3]), 64'd4);
        check("bp in_ready", 64'(ir[3]), 64'd0);
        check("bp head", 64'(od[3]), 64'hA0);
      end
      if (c == 7) begin
        check("bp ready after pop", 64'(ir[3]), 64'd1);
        check("bp second word", 64'(od[3]), 64'hA1);
      end
      step();
      if (acc) begin
        j++;
        id[3] = 8'(8'hA0 + j);
      end
    end
    check("bp all accepted", 64'(j), 64'd6);
    iv[3] = 1'b0;
    for (int c = 0; c < 6; c++) step();
    ordy[3] = 1'b0;

    // Full DEPTH=3 with simultaneous valid and one pop.
    iv[2] = 1'b1;
    id[2] = 8'h31;
    step();
    id[2] = 8'h32;
    step();
    id[2] = 8'h33;
    step();
    id[2] = 8'h34;
    ordy[2] = 1'b1;
    @(negedge clk);
    check("full3 in_ready", 64'(ir[2]), 64'd0);
    check("full3 level", 64'(lvl[2]), 64'd3);
    step();
    ordy[2] = 1'b0;
    @(negedge clk);
    check("full3 after pop level", 64'(lvl[2]), 64'd2);
    check("full3 after pop ready", 64'(ir[2]), 64'd1);
    check("full3 head", 64'(od[2]), 64'h32);
    step();
    iv[2] = 1'b0;
    @(negedge clk);
    check("full3 refill level", 64'(lvl[2]), 64'd3);
    step();
    ordy[2] = 1'b1;
    for (int c = 0; c < 4; c++) step();
    ordy[2] = 1'b0;

    // Timestamp wrap-around.
    cycle_cnt = 32'hFFFF_FFFE;
    iv[1] = 1'b1;
    id[1] = 8'h77;
    step();
    iv[1] = 1'b0;
    step();
    step();
    step();
    step();
    @(negedge clk);
    check("wrap ts", 64'(ots[1]), 64'hFFFF_FFFE);
    check("wrap lat", 64'(olat[1]), 64'd5);
    step();
    ordy[1] = 1'b1;
    step();
    ordy[1] = 1'b0;

    // Flush with push and pop pending; DEPTH=4 shows a discarded push while ready.
    iv[2] = 1'b1;
    iv[3] = 1'b1;
    id[2] = 8'h41;
    id[3] = 8'h91;
    step();
    id[2] = 8'h42;
    id[3] = 8'h92;
    step();
    id[2] = 8'h43;
    id[3] = 8'h93;
    step();
    id[2] = 8'h44;
    id[3] = 8'h99;
    ordy[2] = 1'b1;
    ordy[3] = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("pre flush level", 64'(lvl[2]), 64'd3);
    check("pre flush hwm", 64'(hw[2]), 64'd3);
    check("flush in_ready d4", 64'(ir[3]), 64'd1);
    step();
    flush = 1'b0;
    iv[2] = 1'b0;
    iv[3] = 1'b0;
    ordy[2] = 1'b0;
    ordy[3] = 1'b0;
    @(negedge clk);
    check("flush level", 64'(lvl[2]), 64'd0);
    check("flush out_valid", 64'(ov[2]), 64'd0);
    check("flush hwm", 64'(hw[2]), 64'd0);
    check("flush level d4", 64'(lvl[3]), 64'd0);
    step();
    step();
    @(negedge clk);
    check("flushed word absent", 64'(ov[2]), 64'd0);
    check("flushed push absent", 64'(ov[3]), 64'd0);

    // DEPTH=1 legacy rate: one word per two cycles.
    step();
    iv[0] = 1'b1;
    ordy[0] = 1'b1;
    id[0] = 8'h10;
    acc_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = ir[0];
      step();
      if (acc) begin
        acc_cnt++;
        id[0] = id[0] + 8'd1;
      end
    end
    check("depth1 rate", 64'(acc_cnt), 64'd5);
    iv[0] = 1'b0;
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
